guitar_input_conditioner: RTL
=============================

GUITAR_INPUT_CONDITIONER -- requirements
Module: guitar_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000 (1 ms at 50 MHz), meaning consecutive stable cycles required to accept an input change; legal range 2..65535.
REQ-002 SHALL have port clock  input  1  system clock (CLOCK_50 domain); the block's only clock.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports p1b1, p1b2, p1b3, p2b1, p2b2, p2b3  input  1 each  raw fret buttons, asynchronous, active-low (0 = pressed).
REQ-005 SHALL have ports p1ls, p2ls  input  1 each  raw strum levers, asynchronous, active-high (1 = strummed).
REQ-006 SHALL have port clear_events  input  1  one-cycle processor pulse that clears the sticky hit bits selected by clear_mask.
REQ-007 SHALL have port clear_mask  input  6  per-bit select for clear_events; bit i clears sticky hit bit i.
REQ-008 SHALL have port external_inputs  output  32  status word for the regfile external-inputs port.
REQ-009 SHALL have port event_valid  output  1  high while any sticky hit bit is set.

Function
REQ-010 SHALL pass each of the 8 raw inputs through a 2-flop synchronizer before any other use.
REQ-011 SHALL keep, per input, a debounced "stable" register and a 16-bit counter.
REQ-012 SHALL, per input, reset the counter to 0 on any cycle where the synchronized value equals stable.
REQ-013 SHALL, per input, increment the counter on each cycle where the synchronized value differs from stable.
REQ-014 SHALL, when the counter equals DEBOUNCE_CYCLES-1 and the values still differ, load stable from the synchronized value and clear the counter.
REQ-015 SHALL therefore show a clean raw change on stable exactly DEBOUNCE_CYCLES+2 rising edges after the raw change.
REQ-016 SHALL reject any glitch shorter than DEBOUNCE_CYCLES synchronized cycles; stable SHALL remain unchanged.
REQ-017 SHALL define pressed[i] = ~stable button i, with bits 0..2 = p1b1..p1b3 and bits 3..5 = p2b1..p2b3.
REQ-018 SHALL drive external_inputs[2:0] = pressed[2:0] & stable p1ls, and external_inputs[5:3] = pressed[5:3] & stable p2ls; these bits are combinational from registers.
REQ-019 SHALL detect a strum rising edge per player as stable ls = 1 while the 1-cycle-delayed stable ls = 0.
REQ-020 SHALL, on the edge following a player's strum edge, OR that player's pressed bits into sticky hit bits (player 1 into sticky[2:0], player 2 into sticky[5:3]).
REQ-021 SHALL, on that same edge, increment that player's 4-bit strum counter, wrapping 15 -> 0.
REQ-022 SHALL drive external_inputs[11:6] = sticky[5:0], [15:12] = p1 strum count, [19:16] = p2 strum count, and [31:20] = 0.
REQ-023 SHALL, on a clear_events pulse, clear sticky[i] on the next edge for each i where clear_mask[i] = 1.
REQ-024 SHALL give set priority over clear when a set and a clear target the same sticky bit on the same edge; that bit SHALL end at 1.
REQ-025 SHALL ignore clear_mask while clear_events = 0.
REQ-026 SHALL process both players' strums independently, including strums on the same edge.
REQ-027 SHALL drive event_valid = |sticky, combinational.

Reset
REQ-028 SHALL, while resetn = 0, immediately and asynchronously force:
- button synchronizer flops and button stable registers = 1;
- lever synchronizer flops, lever stable and delayed registers = 0;
- counters, sticky bits and strum counts = 0.
REQ-029 SHALL therefore hold external_inputs = 32'h0 and event_valid = 0 during reset; a debounce in progress when reset asserts is discarded.
REQ-030 SHALL resume normal operation on the first rising edge after resetn deasserts.

Verification (DEBOUNCE_CYCLES = 4)
REQ-031 Reset: assert resetn = 0 with all inputs idle -> external_inputs = 32'h0 and event_valid = 0; no clock edge required.
REQ-032 Bounce: p1b1 low for 3 cycles, then high -> external_inputs stays 32'h0 throughout.
REQ-033 Hit: p1b1 held low and p1ls held high together ->
- external_inputs[0] = 1 on edge 6;
- on the next edge, external_inputs[6] = 1, [15:12] = 4'h1 and event_valid = 1.
REQ-034 Clear:
- clear_events = 1 with clear_mask = 6'b000001 -> bit 6 = 0 on the next edge;
- repeat the clear on the same edge as a new p1 strum with p1b1 held -> bit 6 stays 1.
REQ-035 Wrap: 16 debounced p2ls strums -> [19:16] reads 4'h0 and [15:12] is unchanged.
REQ-036 Reset mid-operation: drop resetn during a debounce count with sticky bits set -> external_inputs = 32'h0 at once; after release, the pending input change needs a full DEBOUNCE_CYCLES+2 edges again.

Source files
------------

// File: rtl/guitar_input_conditioner.sv
// ============================================================================
//  Module      : guitar_input_conditioner
//  Description : Synchronizes and debounces two players' fret buttons and
//                strum levers, latches sticky hit bits on strum edges, keeps
//                per-player strum counters and packs everything into a
//                32-bit status word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module guitar_input_conditioner #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        p1b1,
  input  logic        p1b2,
  input  logic        p1b3,
  input  logic        p2b1,
  input  logic        p2b2,
  input  logic        p2b3,
  input  logic        p1ls,
  input  logic        p2ls,
  input  logic        clear_events,
  input  logic [5:0]  clear_mask,
  output logic [31:0] external_inputs,
  output logic        event_valid
);

  // Last counter value before a differing input is accepted.
  localparam logic [15:0] C_CNT_LAST = DEBOUNCE_CYCLES - 16'd1;
  // Idle level per channel: buttons are active-low (idle 1), levers idle 0.
  localparam logic [7:0]  C_IDLE     = 8'h3F;

  // Channel order: [5:0] buttons p1b1..p2b3, [6] p1 lever, [7] p2 lever.
  logic [7:0] raw;
  logic [7:0] stable;

  assign raw = {p2ls, p1ls, p2b3, p2b2, p2b1, p1b3, p1b2, p1b1};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_chan
      logic        sync1_q;
      logic        sync2_q;
      logic        stable_q;
      logic        stable_d;
      logic [15:0] cnt_q;
      logic [15:0] cnt_d;

      // Count cycles of disagreement; accept the new level once it has held long enough.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = 16'd0;
        if (sync2_q != stable_q) begin
          if (cnt_q == C_CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      // Two-flop synchronizer followed by the debounce state.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          sync1_q  <= C_IDLE[gi];
          sync2_q  <= C_IDLE[gi];
          stable_q <= C_IDLE[gi];
          cnt_q    <= 16'd0;
        end else begin
          sync1_q  <= raw[gi];
          sync2_q  <= sync1_q;
          stable_q <= stable_d;
          cnt_q    <= cnt_d;
        end
      end

      assign stable[gi] = stable_q;
    end
  endgenerate

  logic [5:0] pressed;
  logic       p1_strum;
  logic       p2_strum;
  logic       p1ls_dly_q;
  logic       p2ls_dly_q;
  logic [5:0] sticky_q;
  logic [5:0] sticky_d;
  logic [5:0] set_bits;
  logic [5:0] clr_bits;
  logic [3:0] p1_cnt_q;
  logic [3:0] p1_cnt_d;
  logic [3:0] p2_cnt_q;
  logic [3:0] p2_cnt_d;

  assign pressed  = ~stable[5:0];
  assign p1_strum = stable[6] & ~p1ls_dly_q;
  assign p2_strum = stable[7] & ~p2ls_dly_q;

  // Sticky hit update: clears applied first so a simultaneous set wins.
  always_comb begin
    set_bits = {(p2_strum ? pressed[5:3] : 3'b000),
                (p1_strum ? pressed[2:0] : 3'b000)};
    clr_bits = clear_events ? clear_mask : 6'b000000;
    sticky_d = (sticky_q & ~clr_bits) | set_bits;
    p1_cnt_d = p1_strum ? p1_cnt_q + 4'd1 : p1_cnt_q;
    p2_cnt_d = p2_strum ? p2_cnt_q + 4'd1 : p2_cnt_q;
  end

  // Strum edge history, sticky hits and wrapping strum counters.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      p1ls_dly_q <= 1'b0;
      p2ls_dly_q <= 1'b0;
      sticky_q   <= 6'd0;
      p1_cnt_q   <= 4'd0;
      p2_cnt_q   <= 4'd0;
    end else begin
      p1ls_dly_q <= stable[6];
      p2ls_dly_q <= stable[7];
      sticky_q   <= sticky_d;
      p1_cnt_q   <= p1_cnt_d;
      p2_cnt_q   <= p2_cnt_d;
    end
  end

  assign external_inputs = {12'd0,
                            p2_cnt_q,
                            p1_cnt_q,
                            sticky_q,
                            pressed[5:3] & {3{stable[7]}},
                            pressed[2:0] & {3{stable[6]}}};
  assign event_valid     = |sticky_q;

endmodule

`default_nettype wire
